// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and a constant clog2 shared by FIFO users
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_EXP   = 3;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: storage array with synchronous write and asynchronous read, never reset
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_DEPTH = 2**DEF_ADDR_EXP
) (
    input  logic                           Pclk,
    input  logic                           we,
    input  logic [clog2(ADDR_DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [clog2(ADDR_DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]          rdata
);
    logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

    always_ff @(posedge Pclk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: single-clock show-ahead FIFO with fill count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_EXP   = DEF_ADDR_EXP,
    parameter int ADDR_DEPTH = 2**ADDR_EXP
) (
    input  logic                  Pclk,
    input  logic                  RESET_N,
    input  logic                  ENABLE,
    input  logic                  FLUSH,
    input  logic                  ERR_CLR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [ADDR_EXP:0]     AF_LEVEL,
    input  logic [ADDR_EXP:0]     AE_LEVEL,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [ADDR_EXP:0]     COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);
    localparam int CW = ADDR_EXP + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(ADDR_DEPTH);

    logic [ADDR_EXP-1:0]   wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  active, acc_push, acc_pop, ovf_set, unf_set;
    logic [CW-1:0]         count_nxt;

    // A push into a full FIFO is legal only when a pop frees the slot in the same cycle
    always_comb begin
        active    = ENABLE & ~FLUSH;
        acc_pop   = active & POP & ~EMPTY;
        acc_push  = active & PUSH & (~FULL | acc_pop);
        ovf_set   = active & PUSH & ~acc_push;
        unf_set   = active & POP & EMPTY;
        count_nxt = FLUSH ? '0 : COUNT + CW'(acc_push) - CW'(acc_pop);
    end

    always_ff @(posedge Pclk or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            COUNT        <= '0;
            EMPTY        <= 1'b1;
            FULL         <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else if (ENABLE) begin
            wr_ptr       <= FLUSH ? '0 : wr_ptr + ADDR_EXP'(acc_push);
            rd_ptr       <= FLUSH ? '0 : rd_ptr + ADDR_EXP'(acc_pop);
            COUNT        <= count_nxt;
            EMPTY        <= count_nxt == '0;
            FULL         <= count_nxt == DEPTH_C;
            ALMOST_EMPTY <= count_nxt <= AE_LEVEL;
            ALMOST_FULL  <= count_nxt >= AF_LEVEL;
            OVERFLOW     <= ovf_set | (OVERFLOW & ~ERR_CLR);
            UNDERFLOW    <= unf_set | (UNDERFLOW & ~ERR_CLR);
        end
    end

    fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_DEPTH(ADDR_DEPTH)) u_ram (
        .Pclk  (Pclk),
        .we    (acc_push),
        .waddr (wr_ptr),
        .wdata (DATA_IN),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign DATA_OUT = (EMPTY | ~ENABLE) ? '0 : rd_data;
endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Parametrised successor to the team's single-clock FIFO.
- Adds a fill count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Simultaneous push/pop is only accepted when it is legal, and ENABLE low freezes state instead of wiping it.
- Sits between producer/consumer blocks on the Pclk domain.
- Storage is a non-reset RAM so it can map to block memory.

Parameters:
- DATA_WIDTH, 32, width of DATA_IN/DATA_OUT.
- ADDR_EXP, 3, log2 of depth; depth = 2**ADDR_EXP.
- ADDR_DEPTH, 2**ADDR_EXP, derived; must not be overridden.

Ports:
- Pclk  in  1  clock for all logic.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  block active when 1; when 0, state is frozen.
- FLUSH  in  1  synchronous empty of the FIFO.
- ERR_CLR  in  1  clears OVERFLOW/UNDERFLOW.
- DATA_IN  in  DATA_WIDTH  write data.
- PUSH  in  1  write request.
- POP  in  1  read request; consumes current DATA_OUT.
- AF_LEVEL  in  ADDR_EXP+1  almost-full threshold.
- AE_LEVEL  in  ADDR_EXP+1  almost-empty threshold.
- DATA_OUT  out  DATA_WIDTH  head of FIFO (show-ahead).
- COUNT  out  ADDR_EXP+1  number of stored entries, 0..ADDR_DEPTH.
- FULL  out  1  COUNT == ADDR_DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL.
- OVERFLOW  out  1  sticky: a push was dropped.
- UNDERFLOW  out  1  sticky: a pop hit an empty FIFO.

Behaviour:
- **Reset** (RESET_N low, asynchronous): wr_ptr=0, rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0. RAM contents are not reset. Deassertion is used synchronously to Pclk.
- **Pointers**: ADDR_EXP bits each, natural wrap from ADDR_DEPTH-1 to 0.
- **Handshake**: evaluated only when ENABLE=1 and FLUSH=0.
  - acc_pop = POP & !EMPTY.
  - acc_push = PUSH & (!FULL | acc_pop).
  - Push+pop when FULL: both accepted, COUNT unchanged.
  - Push+pop when EMPTY: push accepted, pop rejected, UNDERFLOW set, COUNT becomes 1.
- **Write**: on acc_push, RAM[wr_ptr] <= DATA_IN; wr_ptr++.
- **Read**: on acc_pop, rd_ptr++.
- **COUNT** next value: COUNT + acc_push - acc_pop.
  - All flags are registered, decoded from next COUNT and current AF_LEVEL/AE_LEVEL, so they are valid the cycle after the push/pop edge.
- **DATA_OUT**: combinational RAM[rd_ptr], forced to 0 when EMPTY or ENABLE=0. Zero-latency show-ahead: a word written at edge N is visible after edge N.
- **Errors**:
  - PUSH & !acc_push sets OVERFLOW; DATA_IN is discarded.
  - POP & EMPTY sets UNDERFLOW.
  - ERR_CLR clears both; a set in the same cycle wins over the clear.
  - FLUSH does not clear errors.
- **FLUSH** (with ENABLE=1): pointers and COUNT go to 0, EMPTY=1, FULL=0, ALMOST_* recomputed for COUNT=0. PUSH/POP in the same cycle are ignored with no error. RAM is untouched.
- **ENABLE=0**: pointers, COUNT, flags and errors hold; PUSH/POP/FLUSH/ERR_CLR are ignored.
- **Thresholds**:
  - AF_LEVEL=0 gives ALMOST_FULL permanently 1; AF_LEVEL > ADDR_DEPTH gives it never 1.
  - AE_LEVEL >= ADDR_DEPTH gives ALMOST_EMPTY permanently 1.
  - Thresholds may change at any time; the new value takes effect at the next edge.
- **Reset mid-operation**: immediate return to reset values regardless of PUSH/POP.

Decomposition:
- **fifo_pkg**: default DATA_WIDTH/ADDR_EXP constants and a clog2 constant function, shared with existing FIFO users.
- **fifo_ram** sub-module: ADDR_DEPTH x DATA_WIDTH, synchronous write, asynchronous read, no reset.
- Control, count, flags and errors stay in fifo_flags.

Test Plan (DATA_WIDTH=32, ADDR_EXP=3, AF_LEVEL=6, AE_LEVEL=1):
- **Reset/idle**: reset, then ENABLE=1 with 3 idle cycles -> COUNT=0, EMPTY=1, ALMOST_EMPTY=1, DATA_OUT=0, errors 0.
- **Fill and overflow**: push 0xA0..0xA7 -> after 6th push ALMOST_FULL=1; after 8th FULL=1, COUNT=8. A 9th push of 0xFF -> OVERFLOW=1, COUNT=8, then pop order is 0xA0..0xA7 with no 0xFF.
- **Full push+pop**: FIFO full, push 0xB0 with pop in the same cycle -> DATA_OUT before the edge = oldest word, COUNT stays 8, FULL stays 1, 0xB0 emerges last.
- **Empty push+pop**: FIFO empty, push 0xC1 with pop in the same cycle -> UNDERFLOW=1, COUNT=1, DATA_OUT=0xC1 next cycle. ERR_CLR with a fresh underfloor-free cycle -> UNDERFLOW=0.
- **Freeze and flush**: COUNT=5, ENABLE=0 with PUSH/POP toggling for 4 cycles -> COUNT=5, DATA_OUT=0. ENABLE=1 -> head word unchanged. FLUSH -> COUNT=0, EMPTY=1, OVERFLOW unchanged.
- **Reset mid-stream and wrap**: pushes and pops interleaved for 20 items (pointer wrap x2) -> data order preserved. Assert RESET_N low mid-burst -> all outputs at reset values within the same cycle.
